// File: rtl/reaction_ctrl_if.sv
// Reaction-timer control bus: button/tick inputs and display/status outputs.
// The optional best-time output exists only when REACTION_BEST_EN is defined.
interface reaction_ctrl_if;
  logic        tick;
  logic        start;
  logic        stop;
  logic        led;
  logic [15:0] bcd;
  logic        done;
  logic        early;
`ifdef REACTION_BEST_EN
  logic [15:0] best;
`endif

  // Stimulus side: drives the tick and buttons, observes the status.
  modport master (
    output tick,
    output start,
    output stop,
    input  led,
    input  bcd,
    input  done,
`ifdef REACTION_BEST_EN
    input  best,
`endif
    input  early
  );

  // Controller side.
  modport slave (
    input  tick,
    input  start,
    input  stop,
    output led,
    output bcd,
    output done,
`ifdef REACTION_BEST_EN
    output best,
`endif
    output early
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer control stage.
// Waits a pseudo-random number of divider ticks after a start press, lights
// the GO LED, then counts ticks in 4-digit BCD until the stop press. Early
// stop presses are flagged and the count saturates at 9999 (timeout).
// Optional feature macro: REACTION_BEST_EN adds a best-time register/output
// that keeps the lowest stop-press result since reset.
module reaction_ctrl #(
  parameter int unsigned MIN_DELAY  = 2,
  parameter logic [7:0]  DELAY_MASK = 8'h07
) (
  input logic            clk,
  input logic            reset,
  reaction_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE,
    S_EARLY
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [8:0]  delay_cnt_q, delay_cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
`ifdef REACTION_BEST_EN
  logic [15:0] best_q, best_d;
`endif

  logic        start_press;
  logic        stop_press;
  logic [8:0]  delay_load;

  // Increment a 4-digit BCD value with decimal carry, saturating at 9999.
  // Digits >= 9 wrap to 0 so a digit can never leave the 0..9 range.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      return v;
    end
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Rising-edge detect against the previous-cycle button levels.
  assign start_press = bus.start & ~start_q;
  assign stop_press  = bus.stop  & ~stop_q;

  // Reload value for the GO delay; 9 bits so MIN_DELAY + mask cannot wrap.
  assign delay_load = 9'(MIN_DELAY) + {1'b0, lfsr_q & DELAY_MASK};

  // Next-state, datapath and LFSR update.
  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    bcd_d       = bcd_q;
    start_d     = bus.start;
    stop_d      = bus.stop;
    // Fibonacci taps 8,6,5,4; a non-zero seed never reaches the all-zero state.
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`ifdef REACTION_BEST_EN
    best_d      = best_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_EARLY: begin
        // A tick in the same cycle as the press is deliberately dropped.
        if (start_press) begin
          state_d     = S_WAIT;
          delay_cnt_d = delay_load;
          bcd_d       = 16'h0000;
        end
      end
      S_WAIT: begin
        // Stop press wins over a simultaneous tick.
        if (stop_press) begin
          state_d = S_EARLY;
        end else if (bus.tick) begin
          if (delay_cnt_q == 9'd1) begin
            state_d = S_GO;
          end else begin
            delay_cnt_d = delay_cnt_q - 9'd1;
          end
        end
      end
      S_GO: begin
        if (stop_press) begin
          // The tick that coincides with the stop press is not counted.
          state_d = S_DONE;
`ifdef REACTION_BEST_EN
          // Valid BCD digits order the same as the raw 16-bit value.
          if (bcd_q < best_q) begin
            best_d = bcd_q;
          end
`endif
        end else if (bus.tick) begin
          if (bcd_q == 16'h9999) begin
            state_d = S_DONE;
          end else begin
            bcd_d = bcd_inc_sat(bcd_q);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 8'h01;
      delay_cnt_q <= 9'd0;
      bcd_q       <= 16'h0000;
      // Buttons held through reset must not look like a press afterwards.
      start_q     <= 1'b1;
      stop_q      <= 1'b1;
`ifdef REACTION_BEST_EN
      best_q      <= 16'h9999;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      delay_cnt_q <= delay_cnt_d;
      bcd_q       <= bcd_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
`ifdef REACTION_BEST_EN
      best_q      <= best_d;
`endif
    end
  end

  // Status outputs decode directly from registered state.
  assign bus.led   = (state_q == S_GO);
  assign bus.done  = (state_q == S_DONE);
  assign bus.early = (state_q == S_EARLY);
  assign bus.bcd   = bcd_q;
`ifdef REACTION_BEST_EN
  assign bus.best  = best_q;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Testbench for reaction_ctrl: vector table plus directed multi-cycle runs.
// A second instance with DELAY_MASK=8'h07 checks the random delay against a
// reference LFSR. Best-time checks build only with REACTION_BEST_EN.
module tb_reaction_ctrl;

  logic clk;
  logic rst_n;
  logic tick_r, start_r, stop_r;
  logic [7:0] m_lfsr;

  int n_checks;
  int n_errors;

  reaction_ctrl_if bus ();
  reaction_ctrl_if bus2 ();

  assign bus.tick   = tick_r;
  assign bus.start  = start_r;
  assign bus.stop   = stop_r;
  assign bus2.tick  = tick_r;
  assign bus2.start = start_r;
  assign bus2.stop  = stop_r;

  reaction_ctrl #(.MIN_DELAY(2), .DELAY_MASK(8'h00)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  reaction_ctrl #(.MIN_DELAY(2), .DELAY_MASK(8'h07)) u_dut2 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4, seed 1, shifts every clock out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'h01;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    logic        t;
    logic        s;
    logic        p;
    logic        led;
    logic [15:0] bcd;
    logic        done;
    logic        early;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic p);
    tick_r  = t;
    start_r = s;
    stop_r  = p;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, start_r, 1'b0);
  endtask

  task automatic slow_tick();
    cyc(1'b1, start_r, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b0, start_r, 1'b0);
  endtask

  // Start press followed by the two ticks of MIN_DELAY: ends in GO, bcd=0.
  task automatic go();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic press_stop();
    cyc(1'b0, start_r, 1'b0);
    cyc(1'b0, start_r, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_r = 1'b0;
    stop_r = 1'b0;
    start_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Start press on the 0x07-mask instance, count ticks until its LED lights.
  task automatic measure2(input string nm);
    int exp_d;
    int cnt;
    exp_d = 2 + int'(m_lfsr & 8'h07);
    cyc(1'b0, 1'b1, 1'b0);
    cnt = 0;
    while (!bus2.led && cnt < 300) begin
      cyc(1'b1, 1'b1, 1'b0);
      cnt++;
    end
    chk(nm, cnt, exp_d);
  endtask

  task automatic expect_out(input string nm, input logic led, input logic [15:0] bcd,
                            input logic done, input logic early);
    chk({nm, "_led"},   bus.led,   led);
    chk({nm, "_bcd"},   bus.bcd,   bcd);
    chk({nm, "_done"},  bus.done,  done);
    chk({nm, "_early"}, bus.early, early);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    //             t     s     p     led   bcd       done  early
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // start held from reset
    vt[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}; // stop ignored in IDLE
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // start -> WAIT
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // delay 2->1
    vt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1}; // stop beats tick
    vt[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1}; // stays EARLY
    vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // start -> WAIT
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}; // GO
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0}; // start ignored in GO
    vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0}; // stop -> DONE
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0}; // held
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // start+tick -> WAIT
    vt[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}; // full delay kept
    vt[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0}; // GO

    // Reset held with start asserted.
    rst_n   = 1'b0;
    tick_r  = 1'b0;
    start_r = 1'b1;
    stop_r  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef REACTION_BEST_EN
    chk("reset_best", bus.best, 16'h9999);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      cyc(vt[i].t, vt[i].s, vt[i].p);
      expect_out($sformatf("vec%0d", i), vt[i].led, vt[i].bcd, vt[i].done, vt[i].early);
    end

    // Asynchronous reset in GO, checked before any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    start_r = 1'b0;
    tick_r  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal run with a tick every 10 clocks.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    slow_tick();
    chk("norm_led_after_t1", bus.led, 1'b0);
    slow_tick();
    chk("norm_led_after_t2", bus.led, 1'b1);
    for (int i = 0; i < 37; i++) slow_tick();
    chk("norm_bcd_37_go", bus.bcd, 16'h0037);
    press_stop();
    expect_out("norm_stop", 1'b0, 16'h0037, 1'b1, 1'b0);
    ticks(5);
    expect_out("norm_hold", 1'b0, 16'h0037, 1'b1, 1'b0);

    // Decimal carry and saturation.
    go();
    ticks(109);
    chk("carry_0109", bus.bcd, 16'h0109);
    ticks(891);
    chk("carry_1000", bus.bcd, 16'h1000);
    ticks(8999);
    chk("sat_9999_bcd", bus.bcd, 16'h9999);
    chk("sat_9999_led", bus.led, 1'b1);
    ticks(1);
    expect_out("timeout", 1'b0, 16'h9999, 1'b1, 1'b0);

    // Stop press and tick together in GO at 0005.
    go();
    ticks(5);
    cyc(1'b1, 1'b1, 1'b1);
    expect_out("stop_tick", 1'b0, 16'h0005, 1'b1, 1'b0);

    // Random delay on the masked instance.
    do_reset();
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b0, 1'b0);
    measure2("lfsr_delay_a");
    press_stop();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    measure2("lfsr_delay_b");
    press_stop();
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
    measure2("lfsr_delay_c");

`ifdef REACTION_BEST_EN
    do_reset();
    chk("best_init", bus.best, 16'h9999);
    go(); ticks(42); press_stop();
    chk("best_42", bus.best, 16'h0042);
    go(); ticks(17); press_stop();
    chk("best_17", bus.best, 16'h0017);
    go(); ticks(30); press_stop();
    chk("best_30", bus.best, 16'h0017);
    go(); ticks(10000);
    chk("best_timeout_done", bus.done, 1'b1);
    chk("best_timeout", bus.best, 16'h0017);
    rst_n = 1'b0;
    #1;
    chk("best_reset", bus.best, 16'h9999);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
